vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx.sv | 197 +++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates from a vga_sync-style stream and tracks sync lock.
// Define VGA_SYNC_RX_ERRCNT_EN to build the saturating sync-error counter behind err_cnt.
module vga_sync_rx #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_RETRACE = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_RETRACE = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_valid,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  localparam int unsigned CW      = 11;
  localparam int unsigned WD_W    = $clog2(2 * H_TOTAL + 1);

  localparam logic [CW-1:0]   H_SYNC_POS = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0]   H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]   V_SYNC_POS = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0]   V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]   H_ACT      = CW'(H_DISPLAY);
  localparam logic [CW-1:0]   V_ACT      = CW'(V_DISPLAY);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(2 * H_TOTAL);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(2 * H_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

  state_e          state_q, state_d;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CW-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic            pix_valid_q, pix_valid_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            locked_q, locked_d;
  logic            sync_err_q, sync_err_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            hs_edge, vs_edge, h_wrap, wd_expire, viol;
  logic [CW-1:0]   vcnt_inc;

  // Edge detection, counters, checks, next state and output staging.
  always_comb begin
    state_d     = state_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    wd_d        = wd_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = pix_valid_q;
    rgb_d       = rgb_q;
    locked_d    = locked_q;
    frame_cnt_d = frame_cnt_q;
    sync_err_d  = 1'b0;
    hs_edge     = 1'b0;
    vs_edge     = 1'b0;
    h_wrap      = 1'b0;
    wd_expire   = 1'b0;
    viol        = 1'b0;
    vcnt_inc    = vcnt_q;

    if (p_tick) begin
      hs_edge = hs_q & ~hsync;
      vs_edge = vs_q & ~vsync;
      hs_d    = hsync;
      vs_d    = vsync;
      h_wrap  = (hcnt_q == H_LAST) && !hs_edge;
      if (h_wrap) begin
        vcnt_inc = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end

      // Watchdog saturates at its limit so an expiry is reported only once.
      if (hs_edge) begin
        wd_d = '0;
      end else if (wd_q != WD_LIMIT) begin
        wd_d      = wd_q + WD_W'(1);
        wd_expire = (wd_q == WD_LAST);
      end

      viol = (state_q != SEARCH) &&
             ((hs_edge && (hcnt_q != H_SYNC_POS)) ||
              (vs_edge && (vcnt_inc != V_SYNC_POS)) ||
              wd_expire);

      if (vs_edge) begin
        hcnt_d = CW'(1);
      end else if (hs_edge) begin
        hcnt_d = H_SYNC_POS + CW'(1);
      end else if (h_wrap) begin
        hcnt_d = '0;
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
      vcnt_d = vs_edge ? V_SYNC_POS : vcnt_inc;

      pix_x_d = vs_edge ? '0 : (hs_edge ? H_SYNC_POS : hcnt_q);
      pix_y_d = vcnt_q;
      rgb_d   = rgb_in;

      case (state_q)
        SEARCH: if (vs_edge) state_d = VERIFY;
        VERIFY: begin
          if (viol)         state_d = SEARCH;
          else if (vs_edge) state_d = LOCKED;
        end
        LOCKED: begin
          if (viol)         state_d     = SEARCH;
          else if (vs_edge) frame_cnt_d = frame_cnt_q + 16'd1;
        end
        default: state_d = SEARCH;
      endcase

      locked_d    = (state_d == LOCKED);
      pix_valid_d = locked_d && (pix_x_d < H_ACT) && (pix_y_d < V_ACT);
      sync_err_d  = viol;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      wd_q        <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      rgb_q       <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      wd_q        <= wd_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      rgb_q       <= rgb_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts violations, sticking at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (viol && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_valid = pix_valid_q;
  assign rgb_out   = rgb_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a reduced raster: a sync source feeds the receiver, a small
// lock/coordinate model fills a scoreboard, and each tick's outputs are checked on the falling edge.
module tb_vga_sync_rx;

  localparam int HD = 16, HF = 2, HR = 4, HB = 3, HT = HD + HF + HR + HB;
  localparam int VD = 8,  VF = 1, VR = 2, VB = 2, VT = VD + VF + VR + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n, p_tick, hsync, vsync;
  logic [11:0] rgb_in;
  logic [10:0] pix_x, pix_y;
  logic        pix_valid, locked, sync_err;
  logic [11:0] rgb_out;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  vga_sync_rx #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_RETRACE(HR), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_RETRACE(VR), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .rgb_out(rgb_out), .locked(locked), .sync_err(sync_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;
  logic [37:0] sb_q[$];

  // Source raster position and disturbances.
  int sx, sy;
  bit hold_hs, stretch_now;
  // Receiver expectation model.
  int st, wd_b, exp_frames, exp_errs, vs_total;
  bit prev_hs, prev_vs, stretch_pending, align_ok;
  // Observation bookkeeping.
  int serr_seen = 0, valid_cnt = 0, win = 0, cur_win = -1;
  bit first_seen;
  logic [21:0] first_xy, last_xy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    st = 0; wd_b = 0; exp_frames = 0; exp_errs = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; stretch_pending = 1'b0; align_ok = 1'b0;
  endtask

  // One pixel tick: drive, predict, sample on the falling edge, then three idle clocks.
  task automatic do_tick();
    logic        hs, vs, hs_f, vs_f, viol, e_lock, e_valid, xy_ok;
    logic [11:0] rgb;
    logic [37:0] e;
    logic [36:0] got, mask;
    hs  = hold_hs ? 1'b1 : !(sx >= HD + HF && sx < HD + HF + HR);
    vs  = !(sy >= VD + VF && sy < VD + VF + VR);
    rgb = 12'($urandom);
    hsync = hs; vsync = vs; rgb_in = rgb; p_tick = 1'b1;

    hs_f = prev_hs && !hs;
    vs_f = prev_vs && !vs;
    prev_hs = hs; prev_vs = vs;
    viol = 1'b0;
    if (hs_f) begin
      if (stretch_pending && st != 0) viol = 1'b1;
      stretch_pending = 1'b0;
      wd_b = 0;
    end else if (wd_b < 2 * HT) begin
      wd_b++;
      if (wd_b == 2 * HT && st != 0) viol = 1'b1;
    end
    if (viol) begin
      st = 0;
      if (exp_errs < 255) exp_errs++;
    end else if (vs_f) begin
      if (st == 2) exp_frames++;
      else st++;
    end
    if (vs_f) vs_total++;
    xy_ok   = align_ok && !stretch_pending && (sx < HT);
    e_lock  = (st == 2);
    e_valid = e_lock && sx < HD && sy < VD;
    e = {xy_ok, e_valid, e_lock, viol, 11'(sx), 11'(sy), rgb};
    if (vs_f) align_ok = 1'b1;
    sb_q.push_back(e);

    @(posedge clk);
    #1 p_tick = 1'b0;
    @(negedge clk);
    e    = sb_q.pop_front();
    got  = {pix_valid, locked, sync_err, pix_x, pix_y, rgb_out};
    mask = e[37] ? {37{1'b1}} : {1'b0, 2'b11, 22'd0, 12'hFFF};
    chk("sample", 64'(got & mask), 64'(e[36:0] & mask));
    if (sync_err) serr_seen++;
    if (pix_valid) begin
      if (cur_win != win) begin cur_win = win; first_seen = 1'b0; end
      if (!first_seen) begin first_xy = {pix_x, pix_y}; first_seen = 1'b1; end
      last_xy = {pix_x, pix_y};
      valid_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;

    sx++;
    if (sx == (stretch_now ? HT + 1 : HT)) begin
      sx = 0;
      sy = (sy == VT - 1) ? 0 : sy + 1;
      if (stretch_now) begin stretch_now = 1'b0; stretch_pending = 1'b1; end
    end
  endtask

  task automatic run_vs(input int n, input string tag);
    int target = vs_total + n;
    int budget = (n + 1) * FT + 10;
    while (vs_total < target && budget > 0) begin do_tick(); budget--; end
    chk(tag, 64'(vs_total), 64'(target));
  endtask

  task automatic run_to(input int x, input int y, input string tag);
    int budget = FT + HT + 10;
    while (!(sx == x && sy == y) && budget > 0) begin do_tick(); budget--; end
    chk(tag, 64'(sx * 1000 + sy), 64'(x * 1000 + y));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    int s0, v0;
    reset_n = 1'b0; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb_in = '0;
    sx = 0; sy = 0; hold_hs = 1'b0; stretch_now = 1'b0; vs_total = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({pix_valid, locked, sync_err, pix_x, pix_y, rgb_out, frame_cnt, err_cnt}), 64'd0);
    reset_n = 1'b1;

    // Loopback acquisition and one full locked frame.
    run_vs(1, "acq_vs1");
    chk("unlocked_after_vs1", 64'(locked), 64'd1 - 64'd1);
    run_vs(1, "acq_vs2");
    chk("locked_at_vs2", 64'(locked), 64'd1);
    win++;
    v0 = valid_cnt;
    run_n(FT);
    chk("valid_per_frame", 64'(valid_cnt - v0), 64'(HD * VD));
    chk("first_valid_xy", 64'(first_xy), 64'({11'd0, 11'd0}));
    chk("last_valid_xy", 64'(last_xy), 64'({11'(HD - 1), 11'(VD - 1)}));

    // One line stretched by a tick.
    run_to(0, 2, "reach_stretch");
    s0 = serr_seen;
    stretch_now = 1'b1;
    run_vs(1, "stretch_vs1");
    chk("stretch_unlocked", 64'(locked), 64'd0);
    chk("stretch_err_pulses", 64'(serr_seen - s0), 64'd1);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    chk("stretch_err_cnt", 64'(err_cnt), 64'd1);
`else
    chk("stretch_err_cnt", 64'(err_cnt), 64'd0);
`endif
    run_vs(1, "stretch_vs2");
    chk("stretch_relock", 64'(locked), 64'd1);

    // hsync held high past the watchdog limit.
    run_to(0, 2, "reach_wd");
    s0 = serr_seen;
    hold_hs = 1'b1;
    run_n(3 * HT);
    hold_hs = 1'b0;
    chk("wd_err_pulses", 64'(serr_seen - s0), 64'd1);
    chk("wd_unlocked", 64'(locked), 64'd0);
    run_vs(2, "wd_relock_vs");
    chk("wd_relock", 64'(locked), 64'd1);

    // Asynchronous reset mid-frame.
    run_to(10, 5, "reach_reset");
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({pix_valid, locked, sync_err, pix_x, pix_y, rgb_out, frame_cnt, err_cnt}), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_vs(1, "rst_vs1");
    chk("rst_unlocked_vs1", 64'(locked), 64'd0);
    run_vs(1, "rst_vs2");
    chk("rst_relock", 64'(locked), 64'd1);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // Three clean locked frames.
    run_vs(3, "clean_vs");
    chk("frame_cnt_3", 64'(frame_cnt), 64'd3);
    chk("frame_cnt_model", 64'(frame_cnt), 64'(exp_frames));
    chk("err_cnt_clean", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
